// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector: compares the last PAT_W sampled bits (MSB = oldest)
// against a runtime-loadable pattern and emits a registered one-cycle match pulse.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             pat_we,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pat_q
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_reg, hist_next, hist_shift;
    logic [FILL_W-1:0] fill_reg, fill_next, fill_inc;
    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              z_reg, z_next;
    logic              match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg <= '0;
            fill_reg <= '0;
            pat_reg  <= PAT_RST;
            cnt_reg  <= '0;
            z_reg    <= 1'b0;
        end else begin
            hist_reg <= hist_next;
            fill_reg <= fill_next;
            pat_reg  <= pat_next;
            cnt_reg  <= cnt_next;
            z_reg    <= z_next;
        end
    end

    always_comb begin
        hist_shift = {hist_reg[PAT_W-2:0], x};
        fill_inc   = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
        match      = 1'b0;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        pat_next   = pat_reg;
        cnt_next   = cnt_reg;
        z_next     = 1'b0;

        // A pattern load wins over sampling; the bit on that edge is dropped.
        if (pat_we) begin
            pat_next  = pat_in;
            hist_next = '0;
            fill_next = '0;
        end else if (en) begin
            hist_next = hist_shift;
            fill_next = fill_inc;
            // fill gate stops reset zeros in hist from matching an all-zero pattern.
            match     = (fill_inc == FILL_FULL) && (hist_shift == pat_reg);
            if (match) begin
                z_next = 1'b1;
                if (!OVERLAP) begin
                    fill_next = '0;
                end
            end
        end

        if (clr_cnt) begin
            cnt_next = '0;
        end else if (match && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign z         = z_reg;
    assign match_cnt = cnt_reg;
    assign pat_q     = pat_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: overlapping, non-overlapping and 2-bit-counter
// instances share one stimulus stream.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       pat_we = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       clr_cnt = 1'b0;

    logic       z_ov, z_nov, z_sat;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_sat;
    logic [3:0] patq_ov, patq_nov, patq_sat;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_detect_param u_ov (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .z(z_ov), .match_cnt(cnt_ov), .pat_q(patq_ov)
    );

    seq_detect_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .z(z_nov), .match_cnt(cnt_nov), .pat_q(patq_nov)
    );

    seq_detect_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .z(z_sat), .match_cnt(cnt_sat), .pat_q(patq_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock with the given x/en, then settle 1 time unit past the edge.
    task automatic step(input logic xv, input logic ev);
        x  = xv;
        en = ev;
        @(posedge clk);
        #1;
        $display("step x=%0b en=%0b z_ov=%0b z_nov=%0b z_sat=%0b cnt_ov=%0d cnt_nov=%0d cnt_sat=%0d",
                 xv, ev, z_ov, z_nov, z_sat, cnt_ov, cnt_nov, cnt_sat);
    endtask

    task automatic do_reset();
        en = 1'b0; x = 1'b0; pat_we = 1'b0; clr_cnt = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic s1   [13] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    logic eov  [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic enov [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    logic g    [4]  = '{1, 0, 1, 1};
    logic sat  [16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    logic [1:0] sat_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        // Reset state
        do_reset();
        chk("rst_z", {31'd0, z_ov}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_ov}, 32'd0);
        chk("rst_patq", {28'd0, patq_ov}, 32'hb);

        // Overlapping and non-overlapping on the same stream
        for (int i = 0; i < 13; i++) begin
            step(s1[i], 1'b1);
            chk($sformatf("ov_z[%0d]", i), {31'd0, z_ov}, {31'd0, eov[i]});
            chk($sformatf("nov_z[%0d]", i), {31'd0, z_nov}, {31'd0, enov[i]});
        end
        chk("ov_cnt", {24'd0, cnt_ov}, 32'd3);
        chk("nov_cnt", {24'd0, cnt_nov}, 32'd2);

        // Sample gating
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(g[i], 1'b1);
            chk($sformatf("gate_z_bit%0d", i), {31'd0, z_ov}, (i == 3) ? 32'd1 : 32'd0);
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 1'b0);
                chk($sformatf("gate_z_idle%0d_%0d", i, k), {31'd0, z_ov}, 32'd0);
            end
        end
        chk("gate_cnt", {24'd0, cnt_ov}, 32'd1);

        // Pattern load mid-stream; the x=1 on the load edge must not complete 1011
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        pat_we = 1'b1;
        pat_in = 4'b0110;
        step(1'b1, 1'b1);
        pat_we = 1'b0;
        chk("load_patq", {28'd0, patq_ov}, 32'h6);
        chk("load_z", {31'd0, z_ov}, 32'd0);
        step(1'b0, 1'b1); chk("load_z0", {31'd0, z_ov}, 32'd0);
        step(1'b1, 1'b1); chk("load_z1", {31'd0, z_ov}, 32'd0);
        step(1'b1, 1'b1); chk("load_z2", {31'd0, z_ov}, 32'd0);
        step(1'b0, 1'b1); chk("load_z3", {31'd0, z_ov}, 32'd1);
        step(1'b0, 1'b0); chk("load_z_end", {31'd0, z_ov}, 32'd0);
        chk("load_cnt", {24'd0, cnt_ov}, 32'd1);

        // All-zero pattern needs four real samples
        do_reset();
        chk("rst_patq2", {28'd0, patq_ov}, 32'hb);
        pat_we = 1'b1;
        pat_in = 4'b0000;
        step(1'b0, 1'b0);
        pat_we = 1'b0;
        chk("zero_patq", {28'd0, patq_ov}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk($sformatf("zero_z%0d", i), {31'd0, z_ov}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Counter saturation (2-bit) and clear priority
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(sat[i], 1'b1);
            if (i % 3 == 0 && i > 0) begin
                chk($sformatf("sat_z%0d", i), {31'd0, z_sat}, 32'd1);
                chk($sformatf("sat_cnt%0d", i), {30'd0, cnt_sat}, {30'd0, sat_cnt[i/3-1]});
            end
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        clr_cnt = 1'b0;
        chk("clr_z", {31'd0, z_sat}, 32'd1);
        chk("clr_cnt", {30'd0, cnt_sat}, 32'd0);

        // Asynchronous reset between edges
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("arst_pre_z", {31'd0, z_ov}, 32'd1);
        chk("arst_pre_cnt", {24'd0, cnt_ov}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_z", {31'd0, z_ov}, 32'd0);
        chk("arst_cnt", {24'd0, cnt_ov}, 32'd0);
        #1;
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1); chk("arst_z1", {31'd0, z_ov}, 32'd0);
        step(1'b0, 1'b1); chk("arst_z2", {31'd0, z_ov}, 32'd0);
        step(1'b1, 1'b1); chk("arst_z3", {31'd0, z_ov}, 32'd0);
        step(1'b1, 1'b1); chk("arst_z4", {31'd0, z_ov}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
